// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Types and default constants shared by the AHB slave front end
//               and the APB controller of the AHB-to-APB bridge.
//               - htrans_t / hresp_t : AHB-Lite transfer and response codes
//               - state_t            : front-end FSM state encoding
//               - c_BASE_ADDR, c_REGION_LOG2, c_NUM_SEL : address map defaults
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_REQ   = 3'd2,
    ST_RSP   = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } state_t;

  localparam logic [31:0] c_BASE_ADDR   = 32'h8000_0000;
  localparam int          c_REGION_LOG2 = 26;
  localparam int          c_NUM_SEL     = 3;

endpackage : ahb_apb_pkg
`default_nettype wire

// File: rtl/ahb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : ahb_addr_decode
// Description : Combinational address decoder for the bridge window.
//               region = (addr - BASE_ADDR) >> REGION_LOG2; a region below
//               NUM_SEL is a hit and drives the matching one-hot select.
//               Addresses below BASE_ADDR are always a miss.
// Ports       : i_addr [ADDR_W]  - address to decode
//               o_hit            - address falls inside a peripheral region
//               o_sel [NUM_SEL]  - one-hot region select (all zero on miss)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(c_BASE_ADDR),
  parameter int                REGION_LOG2 = c_REGION_LOG2,
  parameter int                NUM_SEL     = c_NUM_SEL
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_hit,
  output logic [NUM_SEL-1:0] o_sel
);

  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_region;
  logic              w_above_base;
  logic              w_in_range;

  assign w_offset     = i_addr - BASE_ADDR;
  assign w_region     = w_offset >> REGION_LOG2;
  // The subtraction wraps for addresses below the window, so reject them
  // explicitly rather than relying on the wrapped region being large.
  assign w_above_base = (i_addr >= BASE_ADDR);
  assign w_in_range   = (w_region < ADDR_W'(NUM_SEL));
  assign o_hit        = w_above_base && w_in_range;

  generate
    for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_sel
      assign o_sel[gi] = o_hit && (w_region == ADDR_W'(gi));
    end
  endgenerate

endmodule : ahb_addr_decode
`default_nettype wire

// File: rtl/ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if
// Description : AHB-Lite slave front end of the AHB-to-APB bridge. Accepts
//               single transfers, decodes the target peripheral, hands one
//               request at a time to the APB controller and stalls the master
//               (Hreadyout low) until completion, then returns read data or
//               a two-cycle ERROR response for unmapped addresses.
// Ports       : Hclk, Hreset             - clock, synchronous active-high reset
//               Hwrite, Hreadyin, Htrans,
//               Haddr, Hwdata            - AHB address/data phase inputs
//               Hreadyout, Hresp, Hrdata - AHB slave response outputs
//               req_valid/req_ready      - request handshake to APB controller
//               req_write, req_addr,
//               req_wdata, req_sel       - latched transfer held during request
//               rsp_valid, rsp_rdata     - completion strobe and read data
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(c_BASE_ADDR),
  parameter int                REGION_LOG2 = c_REGION_LOG2,
  parameter int                NUM_SEL     = c_NUM_SEL
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  output logic [NUM_SEL-1:0] req_sel,
  input  logic               rsp_valid,
  input  logic [DATA_W-1:0]  rsp_rdata
);

  state_t             r_state;
  logic               r_hreadyout;
  hresp_t             r_hresp;
  logic [DATA_W-1:0]  r_hrdata;
  logic               r_req_valid;
  logic               r_req_write;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [DATA_W-1:0]  r_req_wdata;
  logic [NUM_SEL-1:0] r_req_sel;

  htrans_t            w_trans;
  logic               w_active;
  logic               w_valid_xfer;
  logic               w_hit;
  logic [NUM_SEL-1:0] w_sel;

  ahb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_LOG2 (REGION_LOG2),
    .NUM_SEL     (NUM_SEL)
  ) u_decode (
    .i_addr (Haddr),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  assign w_trans      = htrans_t'(Htrans);
  // SEQ is treated exactly like NONSEQ: only single transfers are supported.
  assign w_active     = (w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ);
  assign w_valid_xfer = Hreadyin && w_active && (r_state == ST_IDLE);

  // Every output is a register updated alongside the state, so no input
  // reaches an output combinationally.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid_xfer) begin
            r_hreadyout <= 1'b0;
            if (w_hit) begin
              r_req_addr  <= Haddr;
              r_req_write <= Hwrite;
              r_req_sel   <= w_sel;
              if (Hwrite) begin
                r_state <= ST_WDATA;
              end else begin
                r_state     <= ST_REQ;
                r_req_valid <= 1'b1;
              end
            end else begin
              r_state <= ST_ERR1;
              r_hresp <= HRESP_ERROR;
            end
          end
        end
        ST_WDATA: begin
          // Write data belongs to the cycle after the address phase.
          r_req_wdata <= Hwdata;
          r_req_valid <= 1'b1;
          r_state     <= ST_REQ;
        end
        ST_REQ: begin
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_valid) begin
            if (!r_req_write) begin
              r_hrdata <= rsp_rdata;
            end
            r_hreadyout <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_ERR1: begin
          // Second error cycle: ready rises while ERROR is still signalled.
          r_hreadyout <= 1'b1;
          r_state     <= ST_ERR2;
        end
        ST_ERR2: begin
          r_hresp <= HRESP_OKAY;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Hreadyout = r_hreadyout;
  assign Hresp     = r_hresp;
  assign Hrdata    = r_hrdata;
  assign req_valid = r_req_valid;
  assign req_write = r_req_write;
  assign req_addr  = r_req_addr;
  assign req_wdata = r_req_wdata;
  assign req_sel   = r_req_sel;

  // A raised request stays up until the controller accepts it.
  a_req_hold: assert property (@(posedge Hclk) disable iff (Hreset)
    (req_valid && !req_ready) |=> req_valid);

  // An outstanding request always targets exactly one peripheral.
  a_sel_onehot: assert property (@(posedge Hclk) disable iff (Hreset)
    req_valid |-> $onehot(req_sel));

endmodule : ahb_slave_if
`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_if
// Description : Self-checking bench for ahb_slave_if. A table of transfers is
//               applied back to back; expected request fields are queued when
//               the address phase is driven and compared when the DUT raises
//               req_valid or enters the error response. Hand-written sequences
//               cover ignored transfers and reset during an open request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_if;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  always #5 Hclk = ~Hclk;

  ahb_slave_if dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  typedef struct {
    logic        write;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;   // cycles req_ready held low in REQ
    int          rdly;    // idle cycles in RSP before rsp_valid
    logic        hit;
    logic [2:0]  sel;
  } vec_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [2:0]  sel;
  } exp_t;

  localparam int NVEC = 10;
  vec_t  vecs [NVEC];
  exp_t  sb_q [$];
  int    total = 0;
  int    bad   = 0;
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  task automatic recover;
    Hreset = 1'b1;
    tick;
    Hreset = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic do_xfer(input vec_t v);
    exp_t e;
    int   n;
    e.write = v.write; e.addr = v.addr; e.wdata = v.wdata; e.hit = v.hit; e.sel = v.sel;
    // Address phase; Hwdata carries junk that must not be captured.
    Haddr = v.addr; Hwrite = v.write; Htrans = v.trans; Hreadyin = 1'b1; Hwdata = ~v.wdata;
    sb_q.push_back(e);
    tick;
    Htrans = 2'b00; Haddr = 32'h0;
    if (!v.hit) begin
      e = sb_q.pop_front();
      chk("err1 hreadyout", {31'b0, Hreadyout}, 32'd0);
      chk("err1 hresp", {30'b0, Hresp}, 32'd1);
      chk("err1 req_valid", {31'b0, req_valid}, 32'd0);
      tick;
      chk("err2 hreadyout", {31'b0, Hreadyout}, 32'd1);
      chk("err2 hresp", {30'b0, Hresp}, 32'd1);
      tick;
      chk("post-err hresp", {30'b0, Hresp}, 32'd0);
      chk("post-err hrdata", Hrdata, last_rd);
      return;
    end
    if (v.write) begin
      chk("wdata hreadyout", {31'b0, Hreadyout}, 32'd0);
      chk("wdata req_valid", {31'b0, req_valid}, 32'd0);
      Hwdata = v.wdata;
      tick;
      Hwdata = ~v.wdata;
    end
    n = 0;
    while (!req_valid && n < 6) begin
      tick;
      n++;
    end
    chk("req latency", n, 0);
    if (!req_valid) begin
      void'(sb_q.pop_front());
      recover;
      return;
    end
    e = sb_q.pop_front();
    chk("req_write", {31'b0, req_write}, {31'b0, e.write});
    chk("req_addr", req_addr, e.addr);
    chk("req_sel", {29'b0, req_sel}, {29'b0, e.sel});
    if (e.write) chk("req_wdata", req_wdata, e.wdata);
    for (int i = 0; i < v.stall; i++) begin
      req_ready = 1'b0;
      tick;
      chk("req_valid held", {31'b0, req_valid}, 32'd1);
      chk("req_addr held", req_addr, e.addr);
    end
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    chk("rsp req_valid", {31'b0, req_valid}, 32'd0);
    chk("rsp hreadyout", {31'b0, Hreadyout}, 32'd0);
    for (int i = 0; i < v.rdly; i++) begin
      tick;
      chk("rsp wait hreadyout", {31'b0, Hreadyout}, 32'd0);
    end
    rsp_valid = 1'b1; rsp_rdata = v.rdata;
    tick;
    rsp_valid = 1'b0; rsp_rdata = $urandom;
    chk("done hreadyout", {31'b0, Hreadyout}, 32'd1);
    chk("done hresp", {30'b0, Hresp}, 32'd0);
    if (!v.write) last_rd = v.rdata;
    chk("done hrdata", Hrdata, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    //        write trans  addr           wdata          rdata          stall rdly hit  sel
    vecs[0] = '{1'b0, 2'b10, 32'h8000_00A2, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b1, 3'b001};
    vecs[1] = '{1'b1, 2'b10, 32'h8000_0001, 32'h0000_00A3, 32'h1234_5678, 3, 0, 1'b1, 3'b001};
    vecs[2] = '{1'b0, 2'b10, 32'h9000_0000, 32'h0,         32'h0,         0, 0, 1'b0, 3'b000};
    vecs[3] = '{1'b0, 2'b10, 32'h8400_0010, 32'h0,         32'h1111_2222, 0, 0, 1'b1, 3'b010};
    vecs[4] = '{1'b0, 2'b10, 32'h8800_0020, 32'h0,         32'h3333_4444, 0, 0, 1'b1, 3'b100};
    vecs[5] = '{1'b1, 2'b11, 32'h8BFF_FFFC, 32'h0000_5555, 32'hFFFF_0000, 1, 2, 1'b1, 3'b100};
    vecs[6] = '{1'b1, 2'b10, 32'h8C00_0000, 32'h0000_0077, 32'h0,         0, 0, 1'b0, 3'b000};
    vecs[7] = '{1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0,         32'h0,         0, 0, 1'b0, 3'b000};
    vecs[8] = '{1'b0, 2'b11, 32'h8000_0000, 32'h0,         32'h0BAD_F00D, 2, 1, 1'b1, 3'b001};
    vecs[9] = '{1'b1, 2'b11, 32'h87FF_FFFF, 32'hCAFE_0001, 32'h5A5A_5A5A, 0, 0, 1'b1, 3'b010};

    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = 32'h0;
    Hwdata = 32'h0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    last_rd = 32'h0;
    tick;
    tick;
    chk("reset hreadyout", {31'b0, Hreadyout}, 32'd1);
    chk("reset hresp", {30'b0, Hresp}, 32'd0);
    chk("reset hrdata", Hrdata, 32'h0);
    chk("reset req_valid", {31'b0, req_valid}, 32'd0);
    chk("reset req_write", {31'b0, req_write}, 32'd0);
    chk("reset req_addr", req_addr, 32'h0);
    chk("reset req_wdata", req_wdata, 32'h0);
    chk("reset req_sel", {29'b0, req_sel}, 32'd0);
    Hreset = 1'b0;
    tick;

    // Back-to-back: each transfer is presented the cycle Hreadyout returns high.
    for (int i = 0; i < NVEC; i++) do_xfer(vecs[i]);

    // Non-transfers at a hit address, with stray handshake strobes in IDLE.
    for (int i = 0; i < 4; i++) begin
      logic [2:0] t;
      t = (i == 0) ? 3'b001 : (i == 1) ? 3'b011 : (i == 2) ? 3'b100 : 3'b110;
      Htrans = t[2:1]; Hreadyin = t[0]; Hwrite = 1'b0; Haddr = 32'h8000_0010;
      req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hBAAD_0000 + 32'(i);
      tick;
      chk("ignore hreadyout", {31'b0, Hreadyout}, 32'd1);
      chk("ignore req_valid", {31'b0, req_valid}, 32'd0);
      chk("ignore hrdata", Hrdata, last_rd);
    end
    Htrans = 2'b00; Hreadyin = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0;
    tick;

    // Reset while a request is outstanding.
    Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8400_0040;
    tick;
    Htrans = 2'b00;
    chk("pre-reset req_valid", {31'b0, req_valid}, 32'd1);
    Hreset = 1'b1;
    tick;
    Hreset = 1'b0;
    last_rd = 32'h0;
    chk("mid-reset req_valid", {31'b0, req_valid}, 32'd0);
    chk("mid-reset hreadyout", {31'b0, Hreadyout}, 32'd1);
    chk("mid-reset req_addr", req_addr, 32'h0);
    rsp_valid = 1'b1; rsp_rdata = 32'hFEED_FACE;
    tick;
    rsp_valid = 1'b0;
    chk("stale rsp hrdata", Hrdata, 32'h0);
    chk("stale rsp hreadyout", {31'b0, Hreadyout}, 32'd1);
    chk("stale rsp req_valid", {31'b0, req_valid}, 32'd0);

    // A normal read still works after the reset.
    do_xfer('{1'b0, 2'b10, 32'h8400_0044, 32'h0, 32'h0C0F_FEE0, 0, 0, 1'b1, 3'b010});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ahb_slave_if
`default_nettype wire

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB-Lite slave front end of the AHB-to-APB bridge, directly downstream of the AHB master. It samples and validates AHB address and data phases and decodes the target APB peripheral. It hands one transfer at a time to the APB controller over a valid/ready request channel. It holds HREADYOUT low until that controller signals completion, then returns read data or an ERROR response to the master.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- BASE_ADDR, 32'h8000_0000, start of the bridge address window
- REGION_LOG2, 26, log2 of each peripheral region size (64 MiB)
- NUM_SEL, 3, number of APB peripheral regions
- Hclk  in  1  single clock; all logic on rising edge
- Hreset  in  1  synchronous, active-high reset
- Hwrite  in  1  transfer direction, 1 = write
- Hreadyin  in  1  master ready / bus HREADY
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  in  ADDR_W  transfer address
- Hwdata  in  DATA_W  write data, valid in the data phase
- Hreadyout  out  1  slave ready
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  DATA_W  read data
- req_valid  out  1  request to APB controller
- req_ready  in  1  controller accepts request
- req_write, req_addr, req_wdata  out  1/ADDR_W/DATA_W  latched transfer
- req_sel  out  NUM_SEL  one-hot peripheral select
- rsp_valid  in  1  controller completion strobe
- rsp_rdata  in  DATA_W  read data, qualified by rsp_valid

## Operation

- Valid transfer: Hreadyin=1, Htrans[1]=1 (NONSEQ or SEQ), and the FSM in IDLE. Only single transfers; SEQ is handled identically to NONSEQ.
- Decode: region = (Haddr - BASE_ADDR) >> REGION_LOG2. A region < NUM_SEL is a hit and produces the one-hot req_sel; anything else, including below BASE_ADDR, is a miss.
- FSM states: IDLE, WDATA, REQ, RSP, ERR1, ERR2.
- IDLE: Hreadyout=1. On a valid hit, latch addr, write, and sel. Go to WDATA if write, else REQ. On a valid miss, go to ERR1. Otherwise stay.
- WDATA: Hreadyout=0. Capture Hwdata into req_wdata at the closing edge, then go to REQ.
- REQ: Hreadyout=0, req_valid=1, and req_* held stable. On req_ready, go to RSP.
- RSP: Hreadyout=0. On rsp_valid, go to IDLE. For reads, register rsp_rdata into Hrdata on that edge.
- ERR1: Hreadyout=0, Hresp=01. ERR2: Hreadyout=1, Hresp=01, then IDLE. Address inputs are ignored in ERR1/ERR2.
- Hrdata holds its last value until the next read completes.
- Hwdata is ignored outside WDATA. rsp_valid is ignored outside RSP. req_ready is ignored outside REQ.

## Timing

- All outputs are registered or decoded from the state register only (Moore); there are no combinational paths from input to output.
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_sel=0, state=IDLE.
- Reset asserted in any state: on the next edge, return to IDLE with reset values. Any outstanding request is discarded and req_valid drops.
- Read with req_ready tied 1 and rsp_valid one cycle after REQ: address sampled at edge 0; REQ in cycle 1; RSP in cycle 2; Hreadyout=1 with Hrdata valid in cycle 3. Minimum read latency is 3 cycles from the address edge.
- Write: WDATA adds one cycle, giving a minimum of 4 cycles from the address edge to Hreadyout=1.
- req_valid must not drop before req_ready. At most one request is outstanding.
- Error response is exactly two cycles: ERR1 then ERR2.
- A valid address presented in the cycle Hreadyout returns to 1 (IDLE) is accepted, so back-to-back transfers are supported.

## Structure

- Package ahb_apb_pkg holds:
  - htrans_t and hresp_t enums
  - the FSM state enum
  - BASE_ADDR and REGION_LOG2 defaults
  - shared with the APB controller
- Sub-module ahb_addr_decode: combinational map from Haddr to hit and one-hot sel. It is reused by the bridge top for assertions.

## Test plan

- Read 32'h8000_00A2, req_ready=1, rsp_valid one cycle after REQ with rsp_rdata=32'hDEAD_BEEF -> req_sel=001, req_write=0; Hreadyout low for 2 cycles; Hrdata=32'hDEAD_BEEF, Hresp=00.
- Write 32'h8000_0001 with data 32'hA3 -> req_wdata=32'hA3, req_sel=001; req_valid held 3 cycles while req_ready=0, then asserted until accepted.
- Access 32'h9000_0000 (miss) -> no req_valid; Hresp=01 with Hreadyout=0, then Hresp=01 with Hreadyout=1; back to OKAY.
- Htrans=00 or 01, or Hreadyin=0, at a hit address -> no state change, Hreadyout stays 1.
- Hreset asserted in REQ with req_ready=0 -> next edge req_valid=0, Hreadyout=1; a later rsp_valid is ignored.
- Back-to-back reads to 32'h8400_0010 then 32'h8800_0020 -> req_sel=010 then 100; the second address is accepted in the cycle Hreadyout returns to 1.
